// File: rtl/int_ctrl.sv
// Interrupt controller: latches rising-edge requests, picks the lowest-index eligible
// source and holds the control unit in a one-shot SYSCALL/FNSH handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no interrupt in flight; issue on any eligible pending source
// ST_ISSUE   | single cycle, s_interruption high, vector presented
// ST_SERVICE | handler running; waits for s_finish_interr (FNSH)
module int_ctrl #(
  parameter int         NIRQ       = 4,
  parameter logic [9:0] VEC_BASE   = 10'h3C0,
  parameter logic [9:0] VEC_STRIDE = 10'h010
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            cfg_we,
  input  logic [NIRQ:0]   cfg_data,
  input  logic            s_finish_interr,
  output logic            s_interruption,
  output logic [9:0]      vec_addr,
  output logic [2:0]      irq_id,
  output logic            irq_active,
  output logic [NIRQ-1:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] mask;
  logic            gen;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] take;
  logic [NIRQ-1:0] clr;
  logic            any_elig;
  logic            issue_go;
  logic [2:0]      win_id;
  logic [9:0]      id_ext;

  assign rise     = irq & ~irq_q;
  assign eligible = pending & mask & {NIRQ{gen}};
  assign any_elig = |eligible;
  // isolate the lowest set bit: index 0 has the highest priority
  assign take     = eligible & (~eligible + 1'b1);
  assign clr      = take & {NIRQ{issue_go}};

  always_comb begin
    win_id = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 3'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    issue_go  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_elig) begin
          state_nxt = ST_ISSUE;
          issue_go  = 1'b1;
        end
      end
      ST_ISSUE:   state_nxt = ST_SERVICE;
      ST_SERVICE: if (s_finish_interr) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      irq_q   <= '0;
      pending <= '0;
      irq_id  <= '0;
      gen     <= 1'b0;
      mask    <= '0;
    end else begin
      state   <= state_nxt;
      irq_q   <= irq;
      // a new edge on the source being cleared keeps it pending
      pending <= (pending & ~clr) | rise;
      if (issue_go) irq_id <= win_id;
      if (cfg_we) {gen, mask} <= cfg_data;
    end
  end

  assign s_interruption = (state == ST_ISSUE);
  assign irq_active     = (state != ST_IDLE);
  assign id_ext         = {7'b0, irq_id};
  assign vec_addr       = VEC_BASE + id_ext * VEC_STRIDE;

endmodule
